// File: rtl/alu_exec_unit_pkg.sv
// ALU control-code constants shared with the ALU control decoder, plus exec-unit FSM states.
// Consumed by alu_exec_unit and, under ALU_MULT_EN, alu_shift_add_mul.
package alu_exec_unit_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } exec_state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Shift-add multiplier, low WIDTH bits of the unsigned product; WIDTH iterations after start,
// then done is held with the product until the next edge. No backpressure: the caller latches the product on done.
module alu_shift_add_mul
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int MUL_CYCLES = WIDTH;
  localparam int CW         = $clog2(MUL_CYCLES + 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CW'(MUL_CYCLES);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      // Always runs the full count; the done cycle is the one after the last step.
      if (r_cnt != '0) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CW'(1);
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == '0);
  assign o_product = r_acc;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: 1-cycle logic/arith, WIDTH+1-cycle MUL when ALU_MULT_EN is defined (else MUL code is illegal).
// Result/flags are registered and held in DONE until out_ready; in_ready only in IDLE.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  exec_state_t      r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_illegal;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_ill;
  logic             w_is_mul;
  logic             w_accept;

  always_comb begin
    w_sum    = op_a + op_b;
    w_diff   = op_a - op_b;
    w_res    = '0;
    w_ovf    = 1'b0;
    w_ill    = 1'b0;
    w_is_mul = 1'b0;
    case (alu_code)
      ALU_AND: w_res = op_a & op_b;
      ALU_OR:  w_res = op_a | op_b;
      ALU_NOR: w_res = ~(op_a | op_b);
      ALU_ADD: begin
        w_res = w_sum;
        w_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_diff;
        w_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef ALU_MULT_EN
      ALU_MUL: w_is_mul = 1'b1;
`endif
      default: w_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULT_EN
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_prod;

  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_accept && w_is_mul),
    .i_a       (op_a),
    .i_b       (op_b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  assign in_ready = (r_state == ST_IDLE) && !w_mul_busy;
`else
  assign in_ready = (r_state == ST_IDLE);
`endif

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state <= ST_MUL;
            end else begin
              r_result  <= w_res;
              r_zero    <= (w_res == '0);
              r_ovf     <= w_ovf;
              r_illegal <= w_ill;
              r_state   <= ST_DONE;
            end
          end
        end
`ifdef ALU_MULT_EN
        ST_MUL: begin
          if (w_mul_done) begin
            r_result  <= w_mul_prod;
            r_zero    <= (w_mul_prod == '0);
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
            r_state   <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_ovf;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit; MUL expectations follow whether ALU_MULT_EN is defined.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_code  (alu_code),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, measure accept-to-out_valid latency, check outputs, then handshake.
  task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_z, input logic exp_o, input logic exp_i);
    int lat;
    int rdy_hi;
    chk({tag, "_rdy_before"}, in_ready, 1);
    in_valid = 1'b1;
    alu_code = code;
    op_a     = a;
    op_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    rdy_hi   = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_hi++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdy_busy"}, rdy_hi + (in_ready ? 1 : 0), 0);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_zero"}, zero, exp_z);
    chk({tag, "_ovf"}, overflow, exp_o);
    chk({tag, "_ill"}, illegal, exp_i);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_vld_after"}, out_valid, 0);
  endtask

  initial begin
    logic [31:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_code  = 4'b0000;
    op_a      = '0;
    op_b      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_flags", {zero, overflow, illegal}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 0, 1, 0);
    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 1, 0, 0);
    run_op("sub_zero", 4'b0110, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0000, 1, 0, 0);
    run_op("sub_ovf",  4'b0110, 32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 0, 1, 0);
    run_op("slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0001, 0, 0, 0);
    run_op("slt_pos",  4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1, 0, 0);
    run_op("and",      4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 1, 32'h0000_F000, 0, 0, 0);
    run_op("nor",      4'b1100, 32'h0000_0000, 32'h0000_0000, 1, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("ill_0101", 4'b0101, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'h0000_0000, 1, 0, 1);
`ifdef ALU_MULT_EN
    run_op("mul",      4'b1000, 32'h0001_2345, 32'h0000_0100, 33, 32'h0123_4500, 0, 0, 0);
    run_op("mul_wrap", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001, 0, 0, 0);
`else
    run_op("ill_1000", 4'b1000, 32'h0001_2345, 32'h0000_0100, 1, 32'h0000_0000, 1, 0, 1);
`endif

    // OR held under back-pressure while a new AND waits upstream.
    in_valid = 1'b1;
    alu_code = 4'b0001;
    op_a     = 32'h0000_F0F0;
    op_b     = 32'h0000_0F0F;
    @(posedge clk); #1;
    alu_code = 4'b0000;
    op_a     = 32'h0000_00FF;
    op_b     = 32'h0000_0F0F;
    held     = result;
    chk("bp_res", result, 32'h0000_FFFF);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, in_ready, result}, {1'b1, 1'b0, held});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_vld", out_valid, 1);
    chk("bp_next_res", result, 32'h0000_000F);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset while an operation is in flight.
    in_valid = 1'b1;
`ifdef ALU_MULT_EN
    alu_code = 4'b1000;
    op_a     = 32'h0000_0003;
    op_b     = 32'h0000_0007;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
`else
    alu_code = 4'b0001;
    op_a     = 32'h0000_0003;
    op_b     = 32'h0000_0004;
    @(posedge clk); #1;
    in_valid = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    chk("abort_vld", out_valid, 0);
    chk("abort_rdy", in_ready, 1);
    chk("abort_res", result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst_and", 4'b0000, 32'h0000_00FF, 32'h0000_000F, 1, 32'h0000_000F, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
